readout_tx_pulse_sequencer: RTL

Transmit-side counterpart of the readout receive chain. On a trigger it plays a programmable I/Q readout envelope, scaled by a signed amplitude, toward the DAC/up-conversion path. It also generates the time-of-flight-aligned `start_count_out` / `finish_count_out` window markers that the receive-side bin classifier and counter consume. Configuration uses a write-only register port in the same style as the classifier coefficient port.

---
 rtl/readout_pkg.sv | 18 +
 rtl/readout_tx_env_scaler.sv | 35 +++
 rtl/readout_tx_pulse_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared constants and types for the readout transmit sequencer
package readout_pkg;

  localparam logic [2:0] SEL_ENV       = 3'd0;
  localparam logic [2:0] SEL_PULSE_LEN = 3'd1;
  localparam logic [2:0] SEL_TOF       = 3'd2;
  localparam logic [2:0] SEL_AMP       = 3'd3;
  localparam logic [2:0] SEL_WINDOW    = 3'd4;

  typedef enum logic {
    IDLE,
    ACTIVE
  } tx_state_t;

  // Envelope read register plus scale register.
  localparam int TX_LAT = 2;

endpackage

// File: rtl/readout_tx_env_scaler.sv
// rtl/readout_tx_env_scaler.sv - signed Q1.(DW-1) multiply, floor shift, saturate, register
module readout_tx_env_scaler #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] amp,
  output logic signed [DATA_WIDTH-1:0] scaled
);

  localparam logic signed [2*DATA_WIDTH-1:0] SAT_MAX =
    {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [2*DATA_WIDTH-1:0] shifted;
  logic signed [DATA_WIDTH-1:0]   sat;

  // Only (-1)*(-1) can exceed the positive range; the negative side never overflows.
  always_comb begin
    product = (2*DATA_WIDTH)'(sample) * (2*DATA_WIDTH)'(amp);
    shifted = product >>> (DATA_WIDTH - 1);
    sat     = (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scaled <= '0;
    end else begin
      scaled <= in_valid ? sat : '0;
    end
  end

endmodule

// File: rtl/readout_tx_pulse_sequencer.sv
// rtl/readout_tx_pulse_sequencer.sv - triggered I/Q envelope player with ToF-aligned count window markers
module readout_tx_pulse_sequencer
  import readout_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ENV_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [2:0]                   cfg_wr_sel,
  input  logic [ENV_ADDR_WIDTH-1:0]    cfg_wr_addr,
  input  logic [2*DATA_WIDTH-1:0]      cfg_wr_data,
  input  logic                         trigger_in,
  output logic                         busy_out,
  output logic                         trig_dropped_out,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] i_out,
  output logic signed [DATA_WIDTH-1:0] q_out,
  output logic                         start_count_out,
  output logic                         finish_count_out
);

  localparam int DEPTH = 1 << ENV_ADDR_WIDTH;
  localparam int TW    = CNT_WIDTH + 2;
  localparam logic [TW-1:0] DEPTH_T = TW'(DEPTH);

  logic [2*DATA_WIDTH-1:0]      env_mem [DEPTH];
  logic [CNT_WIDTH-1:0]         pulse_len_q;
  logic [CNT_WIDTH-1:0]         tof_q;
  logic [CNT_WIDTH-1:0]         window_q;
  logic signed [DATA_WIDTH-1:0] amp_q;

  tx_state_t state;
  tx_state_t state_next;

  logic [TW-1:0] t_q;
  logic [TW-1:0] len_sh;
  logic [TW-1:0] start_t;
  logic [TW-1:0] finish_t;
  logic [TW-1:0] last_t;
  logic [TW-1:0] len_cfg;
  logic [TW-1:0] tof_cfg;
  logic [TW-1:0] win_cfg;
  logic [TW-1:0] sample_end;
  logic [TW-1:0] window_end;

  logic                      accept;
  logic                      issue;
  logic [ENV_ADDR_WIDTH-1:0] issue_addr;
  logic                      rd_valid;
  logic [2*DATA_WIDTH-1:0]   env_rd;

  // Sequence-relative times: t_q is 1 in the cycle after accept.
  always_comb begin
    len_cfg    = (TW'(pulse_len_q) > DEPTH_T) ? DEPTH_T : TW'(pulse_len_q);
    tof_cfg    = TW'(tof_q);
    win_cfg    = (window_q == '0) ? TW'(1) : TW'(window_q);
    sample_end = len_cfg + TW'(TX_LAT - 1);
    window_end = tof_cfg + win_cfg;
  end

  assign accept   = (state == IDLE) && trigger_in;
  assign busy_out = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sample 0 is fetched in the accept cycle itself so it lands at A+TX_LAT.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = '0;
    case (state)
      IDLE: begin
        if (trigger_in) begin
          state_next = ACTIVE;
          issue      = (len_cfg != '0);
        end
      end
      ACTIVE: begin
        issue      = (t_q < len_sh);
        issue_addr = t_q[ENV_ADDR_WIDTH-1:0];
        if (t_q == last_t) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        env_mem[k] <= '0;
      end
    end else if (cfg_wr_en && (cfg_wr_sel == SEL_ENV)) begin
      env_mem[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_len_q      <= '0;
      tof_q            <= '0;
      window_q         <= '0;
      amp_q            <= '0;
      len_sh           <= '0;
      start_t          <= '0;
      finish_t         <= '0;
      last_t           <= '0;
      t_q              <= '0;
      trig_dropped_out <= 1'b0;
      rd_valid         <= 1'b0;
      env_rd           <= '0;
      valid_out        <= 1'b0;
      start_count_out  <= 1'b0;
      finish_count_out <= 1'b0;
    end else begin
      if (cfg_wr_en) begin
        case (cfg_wr_sel)
          SEL_PULSE_LEN: pulse_len_q <= cfg_wr_data[CNT_WIDTH-1:0];
          SEL_TOF:       tof_q       <= cfg_wr_data[CNT_WIDTH-1:0];
          SEL_AMP:       amp_q       <= cfg_wr_data[DATA_WIDTH-1:0];
          SEL_WINDOW:    window_q    <= cfg_wr_data[CNT_WIDTH-1:0];
          default: ;
        endcase
      end

      if (accept) begin
        len_sh   <= len_cfg;
        start_t  <= tof_cfg + TW'(1);
        finish_t <= window_end;
        last_t   <= (sample_end > window_end) ? sample_end : window_end + TW'(1);
        t_q      <= TW'(1);
      end else if (state == ACTIVE) begin
        t_q <= t_q + TW'(1);
      end

      if ((state == ACTIVE) && trigger_in) begin
        trig_dropped_out <= 1'b1;
      end

      rd_valid         <= issue;
      env_rd           <= issue ? env_mem[issue_addr] : '0;
      valid_out        <= rd_valid;
      start_count_out  <= (state == ACTIVE) && (t_q == start_t);
      finish_count_out <= (state == ACTIVE) && (t_q == finish_t);
    end
  end

  readout_tx_env_scaler #(.DATA_WIDTH(DATA_WIDTH)) u_scale_i (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_valid),
    .sample   (env_rd[2*DATA_WIDTH-1:DATA_WIDTH]),
    .amp      (amp_q),
    .scaled   (i_out)
  );

  readout_tx_env_scaler #(.DATA_WIDTH(DATA_WIDTH)) u_scale_q (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_valid),
    .sample   (env_rd[DATA_WIDTH-1:0]),
    .amp      (amp_q),
    .scaled   (q_out)
  );

endmodule
